vga_brick_renderer: RTL and testbench

- Parametrised next-generation scan/render block for the breakout display. Generates VGA timing with configurable porches and a ROWS x COLS brick field of configurable geometry.
- Draws paddle, ball and live bricks on the 3-bit RGB output.
- Detects ball/brick pixel overlap during the scan and clears the struck brick at the frame boundary. Reports each hit to game logic with a one-cycle pulse.
- Sits between the 25 MHz clock domain game logic (paddle/ball movers) and the VGA connector.

---
 rtl/vga_brick_renderer.sv | 216 +++++++++++++++++++++
 tb/tb_vga_brick_renderer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_brick_renderer.sv
// VGA scan generator and breakout renderer: paddle, ball and a ROWS x COLS
// brick field on 3-bit RGB, with ball/brick hit detection committed once per
// frame at the start of vertical blanking.
module vga_brick_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int ORIGIN_X  = 40,
  parameter int ORIGIN_Y  = 40,
  parameter int BRICK_W   = 80,
  parameter int BRICK_H   = 30,
  parameter int GAP_X     = 40,
  parameter int GAP_Y     = 20,
  parameter int BALL_SIZE = 7,
  parameter int PADDLE_Y  = 440,
  parameter int PADDLE_H  = 10,
  parameter int PADDLE_W  = 100,
  parameter int NB        = ROWS * COLS,
  parameter int IW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          CLK_25MH,
  input  logic          reset,
  input  logic [9:0]    paddle_pos,
  input  logic [9:0]    ball_x,
  input  logic [9:0]    ball_y,
  input  logic          clear_field,
  output logic [2:0]    RGB,
  output logic          hsync,
  output logic          vsync,
  output logic [9:0]    hor_count,
  output logic [9:0]    ver_count,
  output logic          frame_start,
  output logic          hit_valid,
  output logic [IW-1:0] hit_index,
  output logic [IW:0]   bricks_left,
  output logic          field_empty
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PITCH_X = BRICK_W + GAP_X;
  localparam int PITCH_Y = BRICK_H + GAP_Y;
  localparam logic [3:0] COLS_C = 4'(COLS);
  localparam logic [3:0] ROWS_C = 4'(ROWS);

  logic [9:0]    h, v, h_nxt, v_nxt;
  logic          line_end, active, commit;
  logic [9:0]    x_off, y_off;
  logic [3:0]    col, row;           // COLS / ROWS mean "outside the field"
  logic [IW:0]   row_base;           // row*COLS, accumulated instead of multiplied
  logic [IW-1:0] bidx, hit_latch;
  logic [NB-1:0] live;
  logic          in_brick, in_ball, in_paddle, hit_pend, clr_pend, armed;
  logic [10:0]   h_e, v_e;
  logic [2:0]    brick_rgb, pix;

  // next raster position
  always_comb begin
    line_end = (h == 10'(H_TOTAL - 1));
    h_nxt    = line_end ? '0 : h + 10'd1;
    v_nxt    = v;
    if (line_end) v_nxt = (v == 10'(V_TOTAL - 1)) ? '0 : v + 10'd1;
  end

  // raster counters
  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_nxt;
      v <= v_nxt;
    end
  end

  // horizontal brick tracker: offset within pitch and column of the current h
  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      x_off <= '0;
      col   <= (ORIGIN_X == 0) ? 4'd0 : COLS_C;
    end else if (h_nxt == 10'(ORIGIN_X)) begin
      x_off <= '0;
      col   <= '0;
    end else if (h_nxt == '0) begin
      col <= COLS_C;
    end else if (col != COLS_C) begin
      if (x_off == 10'(PITCH_X - 1)) begin
        x_off <= '0;
        col   <= col + 4'd1;
      end else begin
        x_off <= x_off + 10'd1;
      end
    end
  end

  // vertical brick tracker, advanced once per line
  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      y_off    <= '0;
      row      <= (ORIGIN_Y == 0) ? 4'd0 : ROWS_C;
      row_base <= '0;
    end else if (line_end) begin
      if (v_nxt == 10'(ORIGIN_Y)) begin
        y_off    <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (v_nxt == '0) begin
        row <= ROWS_C;
      end else if (row != ROWS_C) begin
        if (y_off == 10'(PITCH_Y - 1)) begin
          y_off    <= '0;
          row      <= row + 4'd1;
          row_base <= row_base + (IW+1)'(COLS);
        end else begin
          y_off <= y_off + 10'd1;
        end
      end
    end
  end

  // region tests on the current pixel (11-bit sums so edges never wrap)
  always_comb begin
    h_e       = {1'b0, h};
    v_e       = {1'b0, v};
    active    = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    commit    = (h == '0) && (v == 10'(V_ACTIVE));
    bidx      = row_base[IW-1:0] + IW'(col);
    in_brick  = (col < COLS_C) && (row < ROWS_C) && (x_off <= 10'(BRICK_W)) &&
                (y_off <= 10'(BRICK_H)) && live[bidx];
    in_ball   = ({1'b0, ball_x} <= h_e) && (h_e <= {1'b0, ball_x} + 11'(BALL_SIZE)) &&
                ({1'b0, ball_y} <= v_e) && (v_e <= {1'b0, ball_y} + 11'(BALL_SIZE));
    in_paddle = ({1'b0, paddle_pos} < h_e) && (h_e < {1'b0, paddle_pos} + 11'(PADDLE_W)) &&
                (v_e > 11'(PADDLE_Y)) && (v_e < 11'(PADDLE_Y + PADDLE_H));
  end

  // brick colour cycles every five rows; then pixel priority mux
  always_comb begin
    case (row[2:0])
      3'd0, 3'd5: brick_rgb = 3'b010;
      3'd1, 3'd6: brick_rgb = 3'b110;
      3'd2, 3'd7: brick_rgb = 3'b111;
      3'd3:       brick_rgb = 3'b101;
      default:    brick_rgb = 3'b011;
    endcase
    pix = 3'b000;
    if (active) begin
      if (in_paddle)     pix = 3'b001;
      else if (in_ball)  pix = 3'b101;
      else if (in_brick) pix = brick_rgb;
    end
  end

  // registered video outputs, all aligned to the pixel on hor/ver_count
  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      RGB         <= 3'b000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      hor_count   <= '0;
      ver_count   <= '0;
      frame_start <= 1'b0;
      armed       <= 1'b0;
    end else begin
      RGB         <= pix;
      hsync       <= !((h >= 10'(H_ACTIVE + H_FP)) && (h < 10'(H_ACTIVE + H_FP + H_SYNC)));
      vsync       <= !((v >= 10'(V_ACTIVE + V_FP)) && (v < 10'(V_ACTIVE + V_FP + V_SYNC)));
      hor_count   <= h;
      ver_count   <= v;
      frame_start <= armed && (h == '0) && (v == '0);   // (0,0) reached by wrap only
      armed       <= 1'b1;
    end
  end

  // hit latch, sticky clear request and frame-boundary commit
  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      live        <= '1;
      bricks_left <= (IW+1)'(NB);
      hit_pend    <= 1'b0;
      clr_pend    <= 1'b0;
      hit_latch   <= '0;
      hit_valid   <= 1'b0;
      hit_index   <= '0;
    end else begin
      hit_valid <= 1'b0;
      if (commit) begin
        hit_pend <= 1'b0;
        clr_pend <= 1'b0;
        if (clr_pend || clear_field) begin
          live        <= '1;
          bricks_left <= (IW+1)'(NB);
        end else if (hit_pend) begin
          live[hit_latch] <= 1'b0;
          bricks_left     <= bricks_left - 1'b1;
          hit_valid       <= 1'b1;
          hit_index       <= hit_latch;
        end
      end else begin
        if (clear_field) clr_pend <= 1'b1;
        if (!hit_pend && active && in_ball && in_brick) begin
          hit_pend  <= 1'b1;
          hit_latch <= bidx;
        end
      end
    end
  end

  assign field_empty = (bricks_left == '0);

endmodule

// File: tb/tb_vga_brick_renderer.sv
// Bench for vga_brick_renderer: a small display geometry, a pixel-level
// reference model computed from coordinates, directed scenarios and random frames.
module tb_vga_brick_renderer;
  localparam int HA = 32, HFP = 2, HS = 4, HBP = 2, HT = HA + HFP + HS + HBP;
  localparam int VA = 40, VFP = 1, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int ROWS = 6, COLS = 2, OX = 2, OY = 2, BW = 10, BH = 3, GX = 6, GY = 3;
  localparam int PX = BW + GX, PY = BH + GY;
  localparam int BS = 2, PYB = 34, PH = 4, PW = 8;
  localparam int NB = ROWS * COLS, IW = $clog2(NB);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [9:0] paddle_pos = 10'd30, ball_x = 10'd1000, ball_y = 10'd1000;
  logic clear_field = 1'b0;
  logic [2:0] RGB;
  logic hsync, vsync, frame_start, hit_valid, field_empty;
  logic [9:0] hor_count, ver_count;
  logic [IW-1:0] hit_index;
  logic [IW:0] bricks_left;

  vga_brick_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .ROWS(ROWS), .COLS(COLS), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .BRICK_W(BW), .BRICK_H(BH), .GAP_X(GX), .GAP_Y(GY),
    .BALL_SIZE(BS), .PADDLE_Y(PYB), .PADDLE_H(PH), .PADDLE_W(PW)
  ) dut (
    .CLK_25MH(clk), .reset(reset), .paddle_pos(paddle_pos), .ball_x(ball_x),
    .ball_y(ball_y), .clear_field(clear_field), .RGB(RGB), .hsync(hsync),
    .vsync(vsync), .hor_count(hor_count), .ver_count(ver_count),
    .frame_start(frame_start), .hit_valid(hit_valid), .hit_index(hit_index),
    .bricks_left(bricks_left), .field_empty(field_empty)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int n;                         // clock edges since reset release
  logic [NB-1:0] m_live = '1;
  int m_left = NB, m_idx = 0;
  bit m_hit = 0, m_clr = 0;
  int e_h = 0, e_v = 0, e_rgb = 0, e_hidx = 0;
  bit e_hs = 1, e_vs = 1, e_fs = 0, e_hv = 0;

  function automatic int brick_at(int x, int y);
    int c, r;
    if (x < OX || y < OY) return -1;
    c = (x - OX) / PX;
    r = (y - OY) / PY;
    if (c >= COLS || r >= ROWS || (x - OX) % PX > BW || (y - OY) % PY > BH) return -1;
    if (!m_live[r * COLS + c]) return -1;
    return r * COLS + c;
  endfunction

  function automatic bit in_ball(int x, int y);
    return x >= int'(ball_x) && x <= int'(ball_x) + BS && y >= int'(ball_y) && y <= int'(ball_y) + BS;
  endfunction

  function automatic int pix_rgb(int x, int y);
    int b;
    if (x >= HA || y >= VA) return 0;
    if (x > int'(paddle_pos) && x < int'(paddle_pos) + PW && y > PYB && y < PYB + PH) return 1;
    if (in_ball(x, y)) return 5;
    b = brick_at(x, y);
    if (b < 0) return 0;
    case ((b / COLS) % 5)
      0: return 2;
      1: return 6;
      2: return 7;
      3: return 5;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    int x, y;
    if (!reset) begin
      n = 0; m_live = '1; m_left = NB; m_hit = 0; m_clr = 0;
      e_h = 0; e_v = 0; e_rgb = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_hv = 0; e_hidx = 0;
    end else begin
      x = n % HT;
      y = (n / HT) % VT;
      e_h = x; e_v = y;
      e_rgb = pix_rgb(x, y);
      e_hs = !(x >= HA + HFP && x < HA + HFP + HS);
      e_vs = !(y >= VA + VFP && y < VA + VFP + VS);
      e_fs = (x == 0 && y == 0 && n > 0);
      e_hv = 0;
      if (x == 0 && y == VA) begin
        if (m_clr || clear_field) begin
          m_live = '1; m_left = NB;
        end else if (m_hit) begin
          m_live[m_idx] = 1'b0; m_left--; e_hv = 1; e_hidx = m_idx;
        end
        m_hit = 0; m_clr = 0;
      end else begin
        if (clear_field) m_clr = 1;
        if (x < HA && y < VA && !m_hit && in_ball(x, y) && brick_at(x, y) >= 0) begin
          m_hit = 1; m_idx = brick_at(x, y);
        end
      end
      n++;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("hor_count", hor_count, e_h);
      chk("ver_count", ver_count, e_v);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("rgb", RGB, e_rgb);
      chk("frame_start", frame_start, e_fs);
      chk("hit_valid", hit_valid, e_hv);
      if (e_hv) chk("hit_index", hit_index, e_hidx);
      chk("bricks_left", bricks_left, m_left);
      chk("field_empty", field_empty, m_left == 0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_pix(input int x, input int y);
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!(hor_count == x && ver_count == y) && k < 2 * FRAME);
    if (k >= 2 * FRAME) chk("wait_pix_timeout", k, 0);
  endtask

  task automatic wait_hit();
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!hit_valid && k < 3 * FRAME);
    if (k >= 3 * FRAME) chk("wait_hit_timeout", k, 0);
  endtask

  task automatic wait_fs();
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!frame_start && k < 2 * FRAME);
    if (k >= 2 * FRAME) chk("wait_fs_timeout", k, 0);
  endtask

  task automatic count_hits(input int cyc, output int hits);
    hits = 0;
    for (int i = 0; i < cyc; i++) begin @(negedge clk); if (hit_valid) hits++; end
  endtask

  task automatic pin_rgb(input string nm, input int x, input int y, input int lit);
    wait_pix(x, y);
    chk(nm, RGB, lit);
    chk({nm, "_model"}, e_rgb, lit);
  endtask

  task automatic ball_away();
    ball_x = 10'd1000; ball_y = 10'd1000;
  endtask

  initial begin
    int k, hits;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    // reset state
    chk("rst_rgb", RGB, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_bricks_left", bricks_left, NB);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    reset = 1'b1;

    // timing: frame period, sync pulse positions and widths
    wait_fs();
    k = 0;
    do begin @(negedge clk); k++; end while (!frame_start && k < 2 * FRAME);
    chk("frame_period", k, FRAME);
    k = 0;
    while (hsync && k < 2 * HT) begin @(negedge clk); k++; end
    chk("hsync_fall_h", hor_count, HA + HFP);
    k = 0;
    while (!hsync && k < 2 * HT) begin @(negedge clk); k++; end
    chk("hsync_width", k, HS);
    k = 0;
    while (vsync && k < 2 * FRAME) begin @(negedge clk); k++; end
    chk("vsync_fall_v", ver_count, VA + VFP);
    k = 0;
    while (!vsync && k < 2 * FRAME) begin @(negedge clk); k++; end
    chk("vsync_width", k, VS * HT);

    // brick field geometry and colours, full field
    pin_rgb("px_2_2", 2, 2, 3'b010);
    pin_rgb("px_13_2", 13, 2, 3'b000);
    pin_rgb("px_18_2", 18, 2, 3'b010);
    pin_rgb("px_12_5", 12, 5, 3'b010);
    pin_rgb("px_2_6", 2, 6, 3'b000);
    pin_rgb("px_2_8", 2, 8, 3'b110);
    pin_rgb("px_2_26", 2, 26, 3'b011);
    pin_rgb("px_2_32", 2, 32, 3'b010);

    // single hit on brick 0, committed at the start of blanking
    wait_fs();
    ball_x = 10'd4; ball_y = 10'd4;
    wait_hit();
    chk("hit0_h", hor_count, 0);
    chk("hit0_v", ver_count, VA);
    chk("hit0_index", hit_index, 0);
    chk("hit0_left", bricks_left, NB - 1);
    pin_rgb("dead_brick", 3, 3, 3'b000);
    pin_rgb("ball_px", 4, 4, 3'b101);
    count_hits(FRAME, hits);
    chk("no_rehit", hits, 0);
    ball_away();

    // clear request in the same frame as a hit on brick 3 wins
    wait_fs();
    ball_x = 10'd20; ball_y = 10'd9;
    clear_field = 1'b1;
    @(negedge clk);
    clear_field = 1'b0;
    count_hits(VA * HT + 20, hits);
    chk("clear_no_hit", hits, 0);
    chk("clear_left", bricks_left, NB);
    pin_rgb("brick3_kept", 24, 9, 3'b110);
    wait_hit();
    chk("hit3_index", hit_index, 3);
    chk("hit3_left", bricks_left, NB - 1);
    ball_away();

    // paddle over ball
    paddle_pos = 10'd10; ball_x = 10'd12; ball_y = 10'd35;
    pin_rgb("paddle_over_ball", 13, 36, 3'b001);
    paddle_pos = 10'd30;
    ball_away();

    // random frames, model-checked every cycle
    for (int f = 0; f < 4; f++) begin
      wait_fs();
      paddle_pos = 10'($urandom_range(0, 40));
      ball_x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 34));
      ball_y = 10'($urandom_range(0, 42));
      for (int i = 0; i < FRAME - 4; i++) begin
        @(negedge clk);
        clear_field = ($urandom_range(0, 2999) == 0);
      end
      clear_field = 1'b0;
    end
    ball_away();

    // restore then clear the whole field one brick per frame
    clear_field = 1'b1;
    @(negedge clk);
    clear_field = 1'b0;
    wait_pix(1, VA);
    chk("restore_left", bricks_left, NB);
    for (int i = 0; i < NB; i++) begin
      ball_x = 10'(OX + PX * (i % COLS) + 3);
      ball_y = 10'(OY + PY * (i / COLS) + 1);
      wait_hit();
      chk("clearall_index", hit_index, i);
    end
    chk("field_empty", field_empty, 1);
    chk("empty_left", bricks_left, 0);

    // asynchronous reset mid-frame
    wait_pix(5, 10);
    #2 reset = 1'b0;
    #1;
    chk("arst_rgb", RGB, 0);
    chk("arst_hsync", hsync, 1);
    chk("arst_vsync", vsync, 1);
    chk("arst_left", bricks_left, NB);
    chk("arst_empty", field_empty, 0);
    chk("arst_hor", hor_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pin_rgb("post_rst", 2, 2, 3'b010);
    chk("post_rst_left", bricks_left, NB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
